// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One output path: data register with a one-cycle valid pulse per load.
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Data holds when not loaded; valid follows load so it drops on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer: steers a qualified word to one of two
// output registers, forming a pipeline boundary for both consuming paths.
module demux_1to2_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_put,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out0_valid,
  output logic             out1_valid
);

  logic load0_c;
  logic load1_c;

  // Enable decode: the two loads are mutually exclusive by construction.
  assign load0_c = in_valid & (sel == SEL_OUT0);
  assign load1_c = in_valid & (sel == SEL_OUT1);

  demux_out_reg #(.WIDTH(WIDTH)) u_out0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load0_c),
    .d       (in_put),
    .q       (out0),
    .q_valid (out0_valid)
  );

  demux_out_reg #(.WIDTH(WIDTH)) u_out1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load1_c),
    .d       (in_put),
    .q       (out1),
    .q_valid (out1_valid)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Directed table-driven bench for demux_1to2_reg.
module tb_demux_1to2_reg;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [15:0] in_put;
  logic        in_valid;
  logic [15:0] out0;
  logic [15:0] out1;
  logic        out0_valid;
  logic        out1_valid;

  int checks;
  int errors;

  typedef struct {
    logic        sel;
    logic        in_valid;
    logic [15:0] in_put;
    logic [15:0] exp_out0;
    logic [15:0] exp_out1;
    logic        exp_v0;
    logic        exp_v1;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  demux_1to2_reg #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .in_put     (in_put),
    .in_valid   (in_valid),
    .out0       (out0),
    .out1       (out1),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic ev0, input logic ev1);
    check({name, ".out0"}, out0, e0);
    check({name, ".out1"}, out1, e1);
    check({name, ".out0_valid"}, 16'(out0_valid), 16'(ev0));
    check({name, ".out1_valid"}, 16'(out1_valid), 16'(ev1));
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic s, input logic v, input logic [15:0] d);
    @(negedge clk);
    sel      = s;
    in_valid = v;
    in_put   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 1'b1, 16'd100,  16'd100,  16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'd200,  16'd200,  16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd300,  16'd300,  16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'd400,  16'd400,  16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'd500,  16'd500,  16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'h0001, 16'h0001, 16'hABCD, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hABCD, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b1};

    // Reset held with an active, all-ones input
    rst_n    = 1'b0;
    sel      = 1'b0;
    in_valid = 1'b1;
    in_put   = 16'hFFFF;
    #2;
    check_all("reset_async", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_edge", 16'h0000, 16'h0000, 1'b0, 1'b0);
    #3;
    check_all("reset_mid", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].sel, vecs[i].in_valid, vecs[i].in_put);
      check_all($sformatf("vec%0d", i), vecs[i].exp_out0, vecs[i].exp_out1,
                vecs[i].exp_v0, vecs[i].exp_v1);
    end

    // Idle: data toggles but nothing is qualified
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'b0, 16'($urandom));
      check_all($sformatf("idle%0d", i), 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    end

    // Select/data glitches between edges, settled before the edge
    @(negedge clk);
    sel      = 1'b0;
    in_valid = 1'b1;
    in_put   = 16'h7777;
    #2;
    sel      = 1'b1;
    in_put   = 16'h3C3C;
    @(posedge clk);
    #1;
    check_all("glitch", 16'h0000, 16'h3C3C, 1'b0, 1'b1);

    // Mid-stream reset pulse between edges
    step(1'b1, 1'b1, 16'h5555);
    check_all("pre_rst", 16'h0000, 16'h5555, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_all("mid_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst_idle", 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h00AA);
    check_all("post_rst_load", 16'h0000, 16'h00AA, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h1111);
    check_all("post_rst_hold", 16'h0000, 16'h00AA, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
